// File: rtl/midi_note_rx.sv
// MIDI input front end: 31250-baud serial receiver plus Note On/Off parser.
// Ports: clk, reset (async active-low), midiRx (serial line, idle high),
//   resetNoteForMem (consumer ack); midiNotes {on,vel,0,note}, noteForMem,
//   midiInterrupt (load pulse), overrun (sticky), frameErr (bad stop pulse).
module midi_note_rx #(
  parameter int         CLKS_PER_BIT   = 1600,
  parameter bit         CHAN_FILTER_EN = 1'b0,
  parameter logic [3:0] CHANNEL        = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        midiRx,
  input  logic        resetNoteForMem,
  output logic [15:0] midiNotes,
  output logic        noteForMem,
  output logic        midiInterrupt,
  output logic        overrun,
  output logic        frameErr
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_M1 =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } bstate_t;

  typedef enum logic [1:0] {
    P_WAIT_STATUS,
    P_WAIT_NOTE,
    P_WAIT_VEL
  } pstate_t;

  // ---------------------------------------------------------------
  // Input synchronizer (resets to the idle line level)
  // ---------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= midiRx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------
  // Byte receiver
  // ---------------------------------------------------------------
  bstate_t       b_st;
  bstate_t       b_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          cnt_clr;
  logic          bit_take;
  logic          byte_valid;
  logic          frame_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b_st <= B_IDLE;
    end else begin
      b_st <= b_nxt;
    end
  end

  always_comb begin
    b_nxt      = b_st;
    cnt_clr    = 1'b0;
    bit_take   = 1'b0;
    byte_valid = 1'b0;
    frame_bad  = 1'b0;
    unique case (b_st)
      B_IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) begin
          b_nxt = B_START;
        end
      end
      B_START: begin
        if (cnt == HALF_M1) begin
          cnt_clr = 1'b1;
          // A line that is high again at mid start bit was a glitch
          if (rx_s) begin
            b_nxt = B_IDLE;
          end else begin
            b_nxt = B_DATA;
          end
        end
      end
      B_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_clr  = 1'b1;
          bit_take = 1'b1;
          if (bit_idx == 3'd7) begin
            b_nxt = B_STOP;
          end
        end
      end
      B_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_clr = 1'b1;
          b_nxt   = B_IDLE;
          if (rx_s) begin
            byte_valid = 1'b1;
          end else begin
            frame_bad = 1'b1;
          end
        end
      end
      default: begin
        b_nxt = B_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
      frameErr <= 1'b0;
    end else begin
      frameErr <= frame_bad;
      if (cnt_clr) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
      if (b_st == B_START) begin
        bit_idx <= 3'd0;
      end else if (bit_take) begin
        bit_idx <= bit_idx + 3'd1;
      end
      // LSB arrives first, so shift in from the top
      if (bit_take) begin
        shreg <= {rx_s, shreg[7:1]};
      end
    end
  end

  // ---------------------------------------------------------------
  // Message parser
  // ---------------------------------------------------------------
  pstate_t    p_st;
  pstate_t    p_nxt;
  logic       rs_valid;
  logic       rs_valid_nxt;
  logic       rs_on;
  logic       rs_on_nxt;
  logic [6:0] note_r;
  logic [6:0] note_nxt;
  logic       done;
  logic       on_bit;
  logic       is_rt;
  logic       is_note_st;
  logic       is_other_st;
  logic       is_data;
  logic       chan_reject;

  assign is_rt       = (shreg[7:3] == 5'b11111);
  assign is_note_st  = (shreg[7:5] == 3'b100);
  assign is_data     = !shreg[7];
  assign is_other_st = shreg[7] && !is_rt && !is_note_st;
  assign chan_reject = CHAN_FILTER_EN &&
                       (shreg[3:0] != CHANNEL);

  // Velocity zero on a Note On is a release
  assign on_bit = rs_on && (shreg[6:0] != 7'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_st     <= P_WAIT_STATUS;
      rs_valid <= 1'b0;
      rs_on    <= 1'b0;
      note_r   <= 7'd0;
    end else begin
      p_st     <= p_nxt;
      rs_valid <= rs_valid_nxt;
      rs_on    <= rs_on_nxt;
      note_r   <= note_nxt;
    end
  end

  always_comb begin
    p_nxt        = p_st;
    rs_valid_nxt = rs_valid;
    rs_on_nxt    = rs_on;
    note_nxt     = note_r;
    done         = 1'b0;
    if (byte_valid) begin
      unique case (1'b1)
        is_rt: begin
          p_nxt = p_st;
        end
        is_note_st: begin
          if (chan_reject) begin
            rs_valid_nxt = 1'b0;
            p_nxt        = P_WAIT_STATUS;
          end else begin
            rs_valid_nxt = 1'b1;
            rs_on_nxt    = shreg[4];
            p_nxt        = P_WAIT_NOTE;
          end
        end
        is_other_st: begin
          rs_valid_nxt = 1'b0;
          p_nxt        = P_WAIT_STATUS;
        end
        is_data: begin
          unique case (p_st)
            P_WAIT_STATUS: begin
              if (rs_valid) begin
                note_nxt = shreg[6:0];
                p_nxt    = P_WAIT_VEL;
              end
            end
            P_WAIT_NOTE: begin
              note_nxt = shreg[6:0];
              p_nxt    = P_WAIT_VEL;
            end
            P_WAIT_VEL: begin
              done  = 1'b1;
              p_nxt = P_WAIT_NOTE;
            end
            default: begin
              p_nxt = P_WAIT_STATUS;
            end
          endcase
        end
        default: begin
          p_nxt = p_st;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Consumer handshake
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      midiNotes     <= 16'h0000;
      noteForMem    <= 1'b0;
      midiInterrupt <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      midiInterrupt <= done;
      if (done) begin
        midiNotes  <= {on_bit, shreg[6:0],
                       1'b0, note_r};
        noteForMem <= 1'b1;
        // An ack in the same cycle consumed the old word
        if (noteForMem && !resetNoteForMem) begin
          overrun <= 1'b1;
        end
      end else if (resetNoteForMem) begin
        noteForMem <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_midi_note_rx.sv
// Bench for midi_note_rx: directed handshake cases plus random byte
// streams scored against a running-status message model.
module tb_midi_note_rx;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        midiRx = 1'b1;
  logic        resetNoteForMem = 1'b0;
  logic [15:0] midiNotes;
  logic        noteForMem;
  logic        midiInterrupt;
  logic        overrun;
  logic        frameErr;

  midi_note_rx #(
    .CLKS_PER_BIT  (CPB),
    .CHAN_FILTER_EN(1'b0),
    .CHANNEL       (4'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .midiRx         (midiRx),
    .resetNoteForMem(resetNoteForMem),
    .midiNotes      (midiNotes),
    .noteForMem     (noteForMem),
    .midiInterrupt  (midiInterrupt),
    .overrun        (overrun),
    .frameErr       (frameErr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  int          cyc = 0;
  int          irq_cnt = 0;
  int          irq_dbl = 0;
  int          irq_cyc = 0;
  int          fe_cnt = 0;
  logic        prev_irq = 1'b0;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (midiInterrupt) begin
      irq_cnt <= irq_cnt + 1;
      irq_cyc <= cyc;
      got_q.push_back(midiNotes);
      if (prev_irq) irq_dbl <= irq_dbl + 1;
    end
    if (frameErr) fe_cnt <= fe_cnt + 1;
    prev_irq <= midiInterrupt;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: running status + pending data bytes
  int         m_rs = -1;
  logic [7:0] m_pend[$];

  task automatic model_reset();
    m_rs = -1;
    m_pend.delete();
  endtask

  task automatic model_byte(input logic [7:0] b,
                            output bit emit,
                            output logic [15:0] w);
    logic [7:0] n;
    logic [7:0] v;
    logic       on;
    emit = 0;
    w = 16'h0;
    if (b >= 8'hF8) return;
    if (b[7]) begin
      m_pend.delete();
      if (b >= 8'h80 && b <= 8'h9F) m_rs = int'(b);
      else m_rs = -1;
      return;
    end
    if (m_rs < 0) return;
    m_pend.push_back(b);
    if (m_pend.size() == 2) begin
      n = m_pend[0];
      v = m_pend[1];
      on = (m_rs >= 'h90) && (v != 8'h00);
      w = {on, v[6:0], 1'b0, n[6:0]};
      emit = 1;
      m_pend.delete();
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input bit bad = 1'b0);
    midiRx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      midiRx = b[i];
      tick(CPB);
    end
    if (bad) begin
      midiRx = 1'b0;
      tick(12);
      midiRx = 1'b1;
      tick(CPB - 12);
    end else begin
      midiRx = 1'b1;
      tick(CPB);
    end
    midiRx = 1'b1;
    tick(CPB / 2);
  endtask

  task automatic send3(input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [7:0] c);
    send_byte(a);
    send_byte(b);
    send_byte(c);
  endtask

  task automatic ack();
    resetNoteForMem = 1'b1;
    tick(1);
    resetNoteForMem = 1'b0;
    tick(1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_notes"}, 32'(midiNotes), 32'h0);
    check({tag, "_nfm"}, 32'(noteForMem), 32'h0);
    check({tag, "_irq"}, 32'(midiInterrupt), 32'h0);
    check({tag, "_ovr"}, 32'(overrun), 32'h0);
    check({tag, "_fe"}, 32'(frameErr), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int i0;
    int f0;
    int t0;
    int lat;
    logic [7:0]  b;
    logic [15:0] w;
    bit          emit;
    int          r;

    tick(1);
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(2);
    check_zero("reset");

    // Basic Note On and ack
    i0 = irq_cnt;
    send3(8'h90, 8'h3C, 8'h64);
    check("t1_irqs", 32'(irq_cnt - i0), 32'd1);
    check("t1_word", 32'(midiNotes), 32'hE43C);
    check("t1_nfm", 32'(noteForMem), 32'd1);
    check("t1_irq_low", 32'(midiInterrupt), 32'd0);
    ack();
    check("t1_nfm_ack", 32'(noteForMem), 32'd0);
    check("t1_hold", 32'(midiNotes), 32'hE43C);

    // Running status and Note Off
    i0 = irq_cnt;
    send3(8'h90, 8'h40, 8'h7F);
    check("t2_w1", 32'(midiNotes), 32'hFF40);
    ack();
    send_byte(8'h43);
    send_byte(8'h00);
    check("t2_w2", 32'(midiNotes), 32'h0043);
    ack();
    send3(8'h80, 8'h3C, 8'h10);
    check("t2_w3", 32'(midiNotes), 32'h103C);
    ack();
    check("t2_irqs", 32'(irq_cnt - i0), 32'd3);
    check("t2_ovr", 32'(overrun), 32'd0);

    // Real-time bytes interleaved
    i0 = irq_cnt;
    send_byte(8'h90);
    send_byte(8'hF8);
    send_byte(8'h3C);
    send_byte(8'hFE);
    send_byte(8'h64);
    check("t3_irqs", 32'(irq_cnt - i0), 32'd1);
    check("t3_word", 32'(midiNotes), 32'hE43C);
    ack();

    // Control change kills running status
    i0 = irq_cnt;
    send3(8'hB0, 8'h07, 8'h64);
    send_byte(8'h3C);
    send_byte(8'h64);
    check("t4_irqs", 32'(irq_cnt - i0), 32'd0);
    check("t4_nfm", 32'(noteForMem), 32'd0);

    // Framing error on the note byte
    i0 = irq_cnt;
    f0 = fe_cnt;
    send_byte(8'h90);
    send_byte(8'h3C, 1'b1);
    check("t5_fe", 32'(fe_cnt - f0), 32'd1);
    check("t5_noirq", 32'(irq_cnt - i0), 32'd0);
    send_byte(8'h3D);
    send_byte(8'h64);
    check("t5_word", 32'(midiNotes), 32'hE43D);
    check("t5_irqs", 32'(irq_cnt - i0), 32'd1);
    ack();

    // Quarter-bit glitch
    i0 = irq_cnt;
    f0 = fe_cnt;
    midiRx = 1'b0;
    tick(CPB / 4);
    midiRx = 1'b1;
    tick(3 * CPB);
    check("t6_fe", 32'(fe_cnt - f0), 32'd0);
    check("t6_irqs", 32'(irq_cnt - i0), 32'd0);
    send_byte(8'h3C);
    send_byte(8'h64);
    check("t6_word", 32'(midiNotes), 32'hE43C);
    ack();

    // Overrun
    i0 = irq_cnt;
    send3(8'h90, 8'h3C, 8'h64);
    check("t7_ovr0", 32'(overrun), 32'd0);
    send_byte(8'h3D);
    send_byte(8'h64);
    check("t7_ovr", 32'(overrun), 32'd1);
    check("t7_word", 32'(midiNotes), 32'hE43D);
    check("t7_nfm", 32'(noteForMem), 32'd1);
    check("t7_irqs", 32'(irq_cnt - i0), 32'd2);

    // Reset mid-byte
    fork
      send_byte(8'h90);
      begin
        tick(5 * CPB);
        reset = 1'b0;
      end
    join
    tick(2);
    reset = 1'b1;
    tick(2);
    check_zero("t8");
    send3(8'h90, 8'h3C, 8'h64);
    check("t8_word", 32'(midiNotes), 32'hE43C);
    check("t8_nfm", 32'(noteForMem), 32'd1);
    ack();

    // Ack coincident with completion
    send_byte(8'h90);
    send_byte(8'h3C);
    t0 = cyc;
    send_byte(8'h64);
    lat = irq_cyc - t0;
    send_byte(8'h3D);
    t0 = cyc;
    fork
      send_byte(8'h64);
      begin
        while (cyc < t0 + lat - 1) tick(1);
        resetNoteForMem = 1'b1;
        tick(1);
        resetNoteForMem = 1'b0;
      end
    join
    check("t9_lat", 32'(irq_cyc - t0), 32'(lat));
    check("t9_nfm", 32'(noteForMem), 32'd1);
    check("t9_ovr", 32'(overrun), 32'd0);
    check("t9_word", 32'(midiNotes), 32'hE43D);
    ack();
    check("t9_nfm_ack", 32'(noteForMem), 32'd0);
    check("dbl_irq", 32'(irq_dbl), 32'd0);

    // Random byte stream vs model
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);
    model_reset();
    got_q.delete();
    exp_q.delete();
    i0 = irq_cnt;
    for (int k = 0; k < 150; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 25) b = 8'h80 | 8'($urandom_range(0, 31));
      else if (r < 32) b = 8'h00;
      else if (r < 70) b = 8'($urandom_range(0, 127));
      else if (r < 80) b = 8'($urandom_range(8'hF8, 8'hFF));
      else b = 8'($urandom_range(8'hA0, 8'hF7));
      model_byte(b, emit, w);
      if (emit) exp_q.push_back(w);
      send_byte(b);
      if (emit) ack();
    end
    check("rnd_irqs", 32'(irq_cnt - i0), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < got_q.size())
        check("rnd_word", 32'(got_q[k]), 32'(exp_q[k]));
    end
    check("rnd_ovr", 32'(overrun), 32'd0);
    check("rnd_nfm", 32'(noteForMem), 32'd0);
    check("rnd_dbl", 32'(irq_dbl), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
